// File: rtl/tlk2711_axil_reg_bridge.sv
// tlk2711_axil_reg_bridge: AXI4-Lite slave that turns each transaction into a
// single-cycle strobe on a simple register bus. Only one transaction is in
// flight at a time, and a write wins when it is requested together with a read.
// Optional build macro: TLK2711_AXIL_DECERR_EN. When it is defined, an address
// above ADDR_LIMIT is not strobed and gets a DECERR response.
module tlk2711_axil_reg_bridge #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ADDR_LIMIT = 32'h0000_01FF
) (
    input  logic                      ps_clk,
    input  logic                      ps_rst,

    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    output logic [1:0]                s_axil_bresp,

    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic [DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                s_axil_rresp,

    output logic                      o_reg_wen,
    output logic [ADDR_WIDTH-1:0]     o_reg_waddr,
    output logic [DATA_WIDTH-1:0]     o_reg_wdata,
    output logic                      o_reg_ren,
    output logic [ADDR_WIDTH-1:0]     o_reg_raddr,
    input  logic [DATA_WIDTH-1:0]     i_reg_rdata
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef TLK2711_AXIL_DECERR_EN
    localparam logic DECERR_EN = 1'b1;
`else
    localparam logic DECERR_EN = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(ADDR_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_EXEC,
        WR_RESP,
        RD_EXEC,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t                  state;
    logic                    aw_held;
    logic                    w_held;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic [1:0]              resp_q;
    logic                    rd_ok_q;
    logic                    rd_idle;
    logic [CNT_WIDTH-1:0]    rd_cnt;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    aw_now;
    logic                    w_now;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [STRB_WIDTH-1:0]   cur_strb;
    logic                    strb_ok;
    logic                    wr_addr_ok;
    logic                    rd_addr_ok;

    // AR is only offered when no write is being requested in the same cycle,
    // so a simultaneous AW/W/AR always resolves to the write first.
    assign s_axil_arready = rd_idle & ~s_axil_awvalid & ~s_axil_wvalid;

    // Handshakes this cycle and the write beat as it will look once both halves are in.
    always_comb begin
        aw_hs      = s_axil_awvalid & s_axil_awready;
        w_hs       = s_axil_wvalid & s_axil_wready;
        ar_hs      = s_axil_arvalid & s_axil_arready;
        aw_now     = aw_held | aw_hs;
        w_now      = w_held | w_hs;
        cur_addr   = aw_held ? awaddr_q : s_axil_awaddr;
        cur_data   = w_held ? wdata_q : s_axil_wdata;
        cur_strb   = w_held ? wstrb_q : s_axil_wstrb;
        strb_ok    = &cur_strb;
        wr_addr_ok = !DECERR_EN || (cur_addr <= LIMIT);
        rd_addr_ok = !DECERR_EN || (s_axil_araddr <= LIMIT);
    end

    // Transaction FSM with all bus-facing outputs registered.
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            state          <= IDLE;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            resp_q         <= RESP_OKAY;
            rd_ok_q        <= 1'b0;
            rd_idle        <= 1'b0;
            rd_cnt         <= '0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= RESP_OKAY;
            o_reg_wen      <= 1'b0;
            o_reg_waddr    <= '0;
            o_reg_wdata    <= '0;
            o_reg_ren      <= 1'b0;
            o_reg_raddr    <= '0;
        end else begin
            case (state)
                IDLE, WR_COLLECT: begin
                    if (aw_hs) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= s_axil_awaddr;
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= s_axil_wdata;
                        wstrb_q <= s_axil_wstrb;
                    end
                    if (aw_now && w_now) begin
                        // Both halves present: issue the strobe next cycle.
                        state          <= WR_EXEC;
                        aw_held        <= 1'b0;
                        w_held         <= 1'b0;
                        s_axil_awready <= 1'b0;
                        s_axil_wready  <= 1'b0;
                        rd_idle        <= 1'b0;
                        if (strb_ok && wr_addr_ok) begin
                            o_reg_wen   <= 1'b1;
                            o_reg_waddr <= cur_addr;
                            o_reg_wdata <= cur_data;
                        end
                        if (!strb_ok) begin
                            resp_q <= RESP_SLVERR;
                        end else if (!wr_addr_ok) begin
                            resp_q <= RESP_DECERR;
                        end else begin
                            resp_q <= RESP_OKAY;
                        end
                    end else if (aw_now || w_now) begin
                        // Half a write is in: keep accepting only the missing half.
                        state          <= WR_COLLECT;
                        s_axil_awready <= !aw_now;
                        s_axil_wready  <= !w_now;
                        rd_idle        <= 1'b0;
                    end else if (ar_hs) begin
                        state          <= RD_EXEC;
                        s_axil_awready <= 1'b0;
                        s_axil_wready  <= 1'b0;
                        rd_idle        <= 1'b0;
                        rd_ok_q        <= rd_addr_ok;
                        resp_q         <= rd_addr_ok ? RESP_OKAY : RESP_DECERR;
                        if (rd_addr_ok) begin
                            o_reg_ren   <= 1'b1;
                            o_reg_raddr <= s_axil_araddr;
                        end
                    end else begin
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                        rd_idle        <= 1'b1;
                    end
                end

                WR_EXEC: begin
                    o_reg_wen     <= 1'b0;
                    o_reg_waddr   <= '0;
                    o_reg_wdata   <= '0;
                    s_axil_bvalid <= 1'b1;
                    s_axil_bresp  <= resp_q;
                    state         <= WR_RESP;
                end

                WR_RESP: begin
                    if (s_axil_bready) begin
                        s_axil_bvalid  <= 1'b0;
                        s_axil_bresp   <= RESP_OKAY;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                        rd_idle        <= 1'b1;
                        state          <= IDLE;
                    end
                end

                RD_EXEC: begin
                    o_reg_ren   <= 1'b0;
                    o_reg_raddr <= '0;
                    rd_cnt      <= CNT_WIDTH'(1);
                    state       <= RD_WAIT;
                end

                RD_WAIT: begin
                    // Sample the read bus exactly RD_LATENCY cycles after the strobe.
                    if (rd_cnt == CNT_WIDTH'(RD_LATENCY)) begin
                        s_axil_rdata  <= rd_ok_q ? i_reg_rdata : '0;
                        s_axil_rresp  <= resp_q;
                        s_axil_rvalid <= 1'b1;
                        state         <= RD_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_WIDTH'(1);
                    end
                end

                RD_RESP: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid  <= 1'b0;
                        s_axil_rdata   <= '0;
                        s_axil_rresp   <= RESP_OKAY;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                        rd_idle        <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Testbench for tlk2711_axil_reg_bridge: directed vector table, corner sequences
// and randomized traffic checked against a transaction-level memory model.
module tb_tlk2711_axil_reg_bridge;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 64;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned LAT   = 2;
    localparam int unsigned LIMIT = 32'h0000_01FF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef TLK2711_AXIL_DECERR_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic            ps_clk = 1'b0;
    logic            ps_rst = 1'b1;
    logic            s_axil_awvalid = 1'b0;
    logic            s_axil_awready;
    logic [AW-1:0]   s_axil_awaddr = '0;
    logic            s_axil_wvalid = 1'b0;
    logic            s_axil_wready;
    logic [DW-1:0]   s_axil_wdata = '0;
    logic [SW-1:0]   s_axil_wstrb = '0;
    logic            s_axil_bvalid;
    logic            s_axil_bready = 1'b0;
    logic [1:0]      s_axil_bresp;
    logic            s_axil_arvalid = 1'b0;
    logic            s_axil_arready;
    logic [AW-1:0]   s_axil_araddr = '0;
    logic            s_axil_rvalid;
    logic            s_axil_rready = 1'b0;
    logic [DW-1:0]   s_axil_rdata;
    logic [1:0]      s_axil_rresp;
    logic            o_reg_wen;
    logic [AW-1:0]   o_reg_waddr;
    logic [DW-1:0]   o_reg_wdata;
    logic            o_reg_ren;
    logic [AW-1:0]   o_reg_raddr;
    logic [DW-1:0]   i_reg_rdata = '0;

    int checks   = 0;
    int failures = 0;

    // Register file behind the bus (written by DUT strobes) and the reference view.
    logic [DW-1:0] slave_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem   [logic [AW-1:0]];

    tlk2711_axil_reg_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .ADDR_LIMIT (LIMIT)
    ) dut (
        .ps_clk         (ps_clk),
        .ps_rst         (ps_rst),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .o_reg_wen      (o_reg_wen),
        .o_reg_waddr    (o_reg_waddr),
        .o_reg_wdata    (o_reg_wdata),
        .o_reg_ren      (o_reg_ren),
        .o_reg_raddr    (o_reg_raddr),
        .i_reg_rdata    (i_reg_rdata)
    );

    always #5 ps_clk = ~ps_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model_wresp(input logic [AW-1:0] a, input logic [SW-1:0] s);
        if (s != {SW{1'b1}}) return RESP_SLVERR;
        if (DEC && (32'(a) > LIMIT)) return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [1:0] model_rresp(input logic [AW-1:0] a);
        if (DEC && (32'(a) > LIMIT)) return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
        if (model_rresp(a) != RESP_OKAY) return '0;
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic any_output();
        return |{s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_bresp,
                 s_axil_rvalid, s_axil_rdata, s_axil_rresp, o_reg_wen, o_reg_waddr,
                 o_reg_wdata, o_reg_ren, o_reg_raddr};
    endfunction

    // One AXI-Lite write with independent AW/W/B delays; checks strobe and response timing.
    task automatic axil_write(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                              input int b_dly, input logic [1:0] exp_resp, input bit exp_strobe);
        int cyc = 0;
        int hs_cyc = -1;
        int wen_cyc = -1;
        int b_first = -1;
        int nwen = 0;
        int bv_low = 0;
        int bdrop = 0;
        int idle_bad = 0;
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit b_done = 1'b0;
        bit bseen = 1'b0;
        logic [AW-1:0] got_addr = '0;
        logic [DW-1:0] got_data = '0;
        logic [1:0]    got_resp = 2'b01;
        while (!b_done && cyc < 100) begin
            @(negedge ps_clk);
            if (o_reg_wen) begin
                nwen++;
                got_addr = o_reg_waddr;
                got_data = o_reg_wdata;
                wen_cyc  = cyc;
                slave_mem[o_reg_waddr] = o_reg_wdata;
            end else if (o_reg_waddr != '0) begin
                idle_bad++;
            end
            if (bseen && !s_axil_bvalid) bdrop++;
            if (s_axil_bvalid && !bseen) begin
                bseen   = 1'b1;
                b_first = cyc;
            end
            s_axil_awvalid = !aw_done && (cyc >= aw_dly);
            s_axil_awaddr  = addr;
            s_axil_wvalid  = !w_done && (cyc >= w_dly);
            s_axil_wdata   = data;
            s_axil_wstrb   = strb;
            s_axil_bready  = bseen && (bv_low >= b_dly);
            #1;
            if (s_axil_awvalid && s_axil_awready) aw_done = 1'b1;
            if (s_axil_wvalid && s_axil_wready) w_done = 1'b1;
            if (aw_done && w_done && hs_cyc < 0) hs_cyc = cyc;
            if (s_axil_bvalid && s_axil_bready) begin
                b_done   = 1'b1;
                got_resp = s_axil_bresp;
            end else if (s_axil_bvalid) begin
                bv_low++;
            end
            cyc++;
        end
        @(negedge ps_clk);
        if (o_reg_wen) nwen++;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        chk({tag, "_bdone"}, 64'(b_done), 64'd1);
        chk({tag, "_bresp"}, 64'(got_resp), 64'(exp_resp));
        chk({tag, "_nwen"}, 64'(nwen), exp_strobe ? 64'd1 : 64'd0);
        if (exp_strobe) begin
            chk({tag, "_waddr"}, 64'(got_addr), 64'(addr));
            chk({tag, "_wdata"}, got_data, data);
            chk({tag, "_wen_cyc"}, 64'(wen_cyc), 64'(hs_cyc + 1));
        end
        chk({tag, "_bvalid_cyc"}, 64'(b_first), 64'(hs_cyc + 2));
        chk({tag, "_bvalid_hold"}, 64'(bdrop), 64'd0);
        chk({tag, "_waddr_idle"}, 64'(idle_bad), 64'd0);
    endtask

    // One AXI-Lite read; the fake slave answers LAT cycles after the strobe, garbage otherwise.
    task automatic axil_read(input string tag, input logic [AW-1:0] addr, input int ar_dly,
                             input int r_dly, input logic [1:0] exp_resp, input bit exp_strobe,
                             input logic [DW-1:0] exp_data);
        int cyc = 0;
        int hs_cyc = -1;
        int ren_cyc = -1;
        int r_first = -1;
        int nren = 0;
        int rv_low = 0;
        int rdrop = 0;
        int rchg = 0;
        int idle_bad = 0;
        bit ar_done = 1'b0;
        bit r_done = 1'b0;
        bit rseen = 1'b0;
        logic [AW-1:0] got_addr = '0;
        logic [DW-1:0] first_data = '0;
        logic [DW-1:0] got_data = '0;
        logic [1:0]    got_resp = 2'b01;
        while (!r_done && cyc < 100) begin
            @(negedge ps_clk);
            if (o_reg_ren) begin
                nren++;
                got_addr = o_reg_raddr;
                ren_cyc  = cyc;
            end else if (o_reg_raddr != '0) begin
                idle_bad++;
            end
            if (rseen && !s_axil_rvalid) rdrop++;
            if (rseen && s_axil_rvalid && s_axil_rdata != first_data) rchg++;
            if (s_axil_rvalid && !rseen) begin
                rseen      = 1'b1;
                r_first    = cyc;
                first_data = s_axil_rdata;
            end
            s_axil_arvalid = !ar_done && (cyc >= ar_dly);
            s_axil_araddr  = addr;
            if (ren_cyc >= 0 && cyc == ren_cyc + int'(LAT))
                i_reg_rdata = slave_mem.exists(got_addr) ? slave_mem[got_addr] : '0;
            else
                i_reg_rdata = {$urandom, $urandom} | 64'h1;
            s_axil_rready = rseen && (rv_low >= r_dly);
            #1;
            if (s_axil_arvalid && s_axil_arready) begin
                ar_done = 1'b1;
                hs_cyc  = cyc;
            end
            if (s_axil_rvalid && s_axil_rready) begin
                r_done   = 1'b1;
                got_data = s_axil_rdata;
                got_resp = s_axil_rresp;
            end else if (s_axil_rvalid) begin
                rv_low++;
            end
            cyc++;
        end
        @(negedge ps_clk);
        if (o_reg_ren) nren++;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        chk({tag, "_rdone"}, 64'(r_done), 64'd1);
        chk({tag, "_rresp"}, 64'(got_resp), 64'(exp_resp));
        chk({tag, "_rdata"}, got_data, exp_data);
        chk({tag, "_nren"}, 64'(nren), exp_strobe ? 64'd1 : 64'd0);
        if (exp_strobe) begin
            chk({tag, "_raddr"}, 64'(got_addr), 64'(addr));
            chk({tag, "_ren_cyc"}, 64'(ren_cyc), 64'(hs_cyc + 1));
        end
        chk({tag, "_rvalid_cyc"}, 64'(r_first), 64'(hs_cyc + 2 + int'(LAT)));
        chk({tag, "_rvalid_hold"}, 64'(rdrop), 64'd0);
        chk({tag, "_rdata_stable"}, 64'(rchg), 64'd0);
        chk({tag, "_raddr_idle"}, 64'(idle_bad), 64'd0);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        int            d0;
        int            d1;
        int            d2;
        logic [1:0]    exp_resp;
        bit            exp_strobe;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int b_hs;
        int ar_hs;
        int cyc;
        int nwen;
        int stray;
        bit aw_d;
        bit w_d;
        bit r_d;
        logic [DW-1:0] got;
        logic [1:0]    gresp;

        // Directed vectors: {wr, addr, data, strb, delays, expected resp/strobe/rdata}.
        // Write delays are AW/W/B; read delays are AR/(unused)/R.
        vecs[0]  = '{wr:1'b1, addr:16'h0108, data:64'h1234, strb:8'hFF, d0:0, d1:0, d2:0,
                     exp_resp:RESP_OKAY, exp_strobe:1'b1, exp_rdata:64'h0};
        vecs[1]  = '{wr:1'b1, addr:16'h0040, data:64'hCAFE_F00D, strb:8'hFF, d0:3, d1:0, d2:5,
                     exp_resp:RESP_OKAY, exp_strobe:1'b1, exp_rdata:64'h0};
        vecs[2]  = '{wr:1'b1, addr:16'h0010, data:64'hA5A5, strb:8'hFF, d0:0, d1:0, d2:0,
                     exp_resp:RESP_OKAY, exp_strobe:1'b1, exp_rdata:64'h0};
        vecs[3]  = '{wr:1'b0, addr:16'h0010, data:64'h0, strb:8'h00, d0:0, d1:0, d2:4,
                     exp_resp:RESP_OKAY, exp_strobe:1'b1, exp_rdata:64'hA5A5};
        vecs[4]  = '{wr:1'b1, addr:16'h0020, data:64'hDEAD, strb:8'h0F, d0:0, d1:0, d2:0,
                     exp_resp:RESP_SLVERR, exp_strobe:1'b0, exp_rdata:64'h0};
        vecs[5]  = '{wr:1'b0, addr:16'h0020, data:64'h0, strb:8'h00, d0:1, d1:0, d2:0,
                     exp_resp:RESP_OKAY, exp_strobe:1'b1, exp_rdata:64'h0};
        vecs[6]  = '{wr:1'b1, addr:16'h01FF, data:64'h01FF_01FF, strb:8'hFF, d0:1, d1:2, d2:1,
                     exp_resp:RESP_OKAY, exp_strobe:1'b1, exp_rdata:64'h0};
        vecs[7]  = '{wr:1'b0, addr:16'h01FF, data:64'h0, strb:8'h00, d0:0, d1:0, d2:2,
                     exp_resp:RESP_OKAY, exp_strobe:1'b1, exp_rdata:64'h01FF_01FF};
        vecs[8]  = '{wr:1'b0, addr:16'h0200, data:64'h0, strb:8'h00, d0:0, d1:0, d2:0,
                     exp_resp:(DEC ? RESP_DECERR : RESP_OKAY), exp_strobe:!DEC, exp_rdata:64'h0};
        vecs[9]  = '{wr:1'b1, addr:16'h0200, data:64'h77, strb:8'hFF, d0:2, d1:0, d2:0,
                     exp_resp:(DEC ? RESP_DECERR : RESP_OKAY), exp_strobe:!DEC, exp_rdata:64'h0};
        vecs[10] = '{wr:1'b0, addr:16'h0108, data:64'h0, strb:8'h00, d0:0, d1:0, d2:0,
                     exp_resp:RESP_OKAY, exp_strobe:1'b1, exp_rdata:64'h1234};

        // Reset: everything low while asserted, ready raised right after release.
        repeat (3) @(negedge ps_clk);
        chk("reset_outputs_zero", 64'(any_output()), 64'd0);
        ps_rst = 1'b0;
        @(negedge ps_clk);
        chk("reset_release_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h7);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr)
                axil_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                           vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].exp_resp, vecs[i].exp_strobe);
            else
                axil_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].d0, vecs[i].d2,
                          vecs[i].exp_resp, vecs[i].exp_strobe, vecs[i].exp_rdata);
        end

        // Simultaneous AW/W/AR: the write must fully finish before AR is accepted.
        @(negedge ps_clk);
        s_axil_awvalid = 1'b1; s_axil_awaddr = 16'h0030;
        s_axil_wvalid  = 1'b1; s_axil_wdata  = 64'h3030; s_axil_wstrb = 8'hFF;
        s_axil_arvalid = 1'b1; s_axil_araddr = 16'h0030;
        i_reg_rdata    = 64'h3030;
        #1;
        chk("simul_arready_low", 64'(s_axil_arready), 64'd0);
        b_hs = -1; ar_hs = -1; cyc = 0; nwen = 0;
        aw_d = 1'b0; w_d = 1'b0; r_d = 1'b0; got = '0; gresp = 2'b01;
        if (s_axil_awready) aw_d = 1'b1;
        if (s_axil_wready) w_d = 1'b1;
        while (!r_d && cyc < 60) begin
            @(negedge ps_clk);
            if (o_reg_wen) nwen++;
            s_axil_awvalid = !aw_d;
            s_axil_wvalid  = !w_d;
            s_axil_arvalid = (ar_hs < 0);
            s_axil_bready  = s_axil_bvalid;
            s_axil_rready  = s_axil_rvalid;
            #1;
            if (s_axil_awvalid && s_axil_awready) aw_d = 1'b1;
            if (s_axil_wvalid && s_axil_wready) w_d = 1'b1;
            if (s_axil_bvalid && s_axil_bready) b_hs = cyc;
            if (s_axil_arvalid && s_axil_arready && ar_hs < 0) ar_hs = cyc;
            if (s_axil_rvalid && s_axil_rready) begin
                r_d   = 1'b1;
                got   = s_axil_rdata;
                gresp = s_axil_rresp;
            end
            cyc++;
        end
        @(negedge ps_clk);
        s_axil_arvalid = 1'b0; s_axil_bready = 1'b0; s_axil_rready = 1'b0;
        chk("simul_write_strobes", 64'(nwen), 64'd1);
        chk("simul_b_done", 64'(b_hs >= 0), 64'd1);
        chk("simul_ar_after_b", 64'(ar_hs > b_hs), 64'd1);
        chk("simul_read_done", 64'(r_d), 64'd1);
        chk("simul_rdata", got, 64'h3030);
        chk("simul_rresp", 64'(gresp), 64'(RESP_OKAY));

        // Reset while the read is waiting on the slave latency.
        s_axil_arvalid = 1'b1; s_axil_araddr = 16'h0108;
        #1;
        chk("rst_mid_arready", 64'(s_axil_arready), 64'd1);
        @(negedge ps_clk);
        s_axil_arvalid = 1'b0;
        chk("rst_mid_ren", 64'(o_reg_ren), 64'd1);
        @(negedge ps_clk);
        ps_rst = 1'b1;
        #1;
        chk("rst_mid_outputs_zero", 64'(any_output()), 64'd0);
        repeat (2) @(negedge ps_clk);
        ps_rst = 1'b0;
        @(negedge ps_clk);
        chk("rst_mid_release_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h7);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ps_clk);
            if (s_axil_rvalid || s_axil_bvalid || o_reg_wen || o_reg_ren) stray++;
        end
        chk("rst_mid_no_stray", 64'(stray), 64'd0);
        axil_read("rst_mid_next", 16'h0108, 0, 0, RESP_OKAY, 1'b1, 64'h1234);

        // Randomized traffic against the transaction-level model.
        slave_mem.delete();
        ref_mem.delete();
        for (int i = 0; i < 40; i++) begin
            int unsigned r;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [SW-1:0] s;
            logic [1:0]    resp;
            r = $urandom_range(0, 9);
            a = (r == 9) ? 16'h0200 : (r == 8) ? 16'h01FF : 16'(r * 8);
            if ($urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom};
                s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
                resp = model_wresp(a, s);
                axil_write($sformatf("rnd%0d", i), a, d, s, $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3), resp, resp == RESP_OKAY);
                if (resp == RESP_OKAY) ref_mem[a] = d;
            end else begin
                resp = model_rresp(a);
                axil_read($sformatf("rnd%0d", i), a, $urandom_range(0, 3), $urandom_range(0, 3),
                          resp, resp == RESP_OKAY, model_rdata(a));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlk2711_axil_reg_bridge.md
TLK2711_AXIL_REG_BRIDGE -- requirements
Module: tlk2711_axil_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, width of AXI-Lite and register-bus addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, width of AXI-Lite and register-bus data.
REQ-003 SHALL have parameter RD_LATENCY, default 1 (range 1-4), cycles from o_reg_ren high to i_reg_rdata valid.
REQ-004 SHALL have parameter ADDR_LIMIT, default 16'h01FF, highest decoded register address.
REQ-005 SHALL have ports: ps_clk, in, 1, single clock for all logic; ps_rst, in, 1, asynchronous active-high reset.
REQ-006 SHALL have AXI-Lite write ports: s_axil_awvalid in 1; s_axil_awready out 1; s_axil_awaddr in ADDR_WIDTH; s_axil_wvalid in 1; s_axil_wready out 1; s_axil_wdata in DATA_WIDTH; s_axil_wstrb in DATA_WIDTH/8; s_axil_bvalid out 1; s_axil_bready in 1; s_axil_bresp out 2.
REQ-007 SHALL have AXI-Lite read ports: s_axil_arvalid in 1; s_axil_arready out 1; s_axil_araddr in ADDR_WIDTH; s_axil_rvalid out 1; s_axil_rready in 1; s_axil_rdata out DATA_WIDTH; s_axil_rresp out 2.
REQ-008 SHALL have register-bus ports: o_reg_wen out 1; o_reg_waddr out ADDR_WIDTH; o_reg_wdata out DATA_WIDTH; o_reg_ren out 1; o_reg_raddr out ADDR_WIDTH; i_reg_rdata in DATA_WIDTH (OR of all slave read buses).

Function
REQ-009 SHALL run FSM states IDLE, WR_COLLECT, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP; one transaction outstanding at a time.
REQ-010 SHALL assert s_axil_awready in IDLE/WR_COLLECT while no AW is held, and s_axil_wready in IDLE/WR_COLLECT while no W is held; AW and W accepted independently in either order.
REQ-011 SHALL move IDLE->WR_COLLECT when only one of AW/W handshakes, and to WR_EXEC on the edge where both are held.
REQ-012 SHALL, in WR_EXEC, drive o_reg_wen high for exactly one cycle with the captured o_reg_waddr/o_reg_wdata, then enter WR_RESP.
REQ-013 SHALL hold s_axil_bvalid high in WR_RESP until s_axil_bready, then return to IDLE; AW+W handshake at edge N gives o_reg_wen in cycle N+1 and bvalid from cycle N+2.
REQ-014 SHALL suppress o_reg_wen and return bresp=2'b10 (SLVERR) when the captured wstrb is not all ones.
REQ-015 SHALL assert s_axil_arready only in IDLE while s_axil_awvalid and s_axil_wvalid are both low (write priority on simultaneous requests).
REQ-016 SHALL, after AR handshake at edge N, drive o_reg_ren high for one cycle (N+1) with o_reg_raddr, count RD_LATENCY cycles in RD_WAIT, register i_reg_rdata at that cycle, and assert s_axil_rvalid in the following cycle.
REQ-017 SHALL hold s_axil_rvalid, s_axil_rdata and s_axil_rresp stable until s_axil_rready, then return to IDLE.
REQ-018 SHALL drive o_reg_waddr/o_reg_raddr to zero whenever o_reg_wen/o_reg_ren is low.
REQ-019 SHALL return bresp/rresp 2'b00 (OKAY) unless REQ-014 or REQ-023 applies.

Reset
REQ-020 SHALL, while ps_rst is high, force FSM to IDLE and all outputs to zero, including the awready/wready/arready outputs.
REQ-021 SHALL discard any held AW/W/AR and pending response on reset mid-transaction; no register strobe or response is issued afterwards.
REQ-022 SHALL raise awready, wready and arready in the first cycle after ps_rst falls.

Configuration
REQ-023 SHALL, with macro TLK2711_AXIL_DECERR_EN defined, suppress o_reg_wen/o_reg_ren for any address > ADDR_LIMIT and respond with resp=2'b11 (DECERR), keeping response timing identical to a decoded access (rdata=0).
REQ-024 SHALL, without TLK2711_AXIL_DECERR_EN, strobe every address and never return DECERR.

Verification
REQ-025 SHALL cover: AW 16'h0108 and W 64'h1234 (strb FF) in the same cycle -> o_reg_wen one cycle later at addr 16'h0108, bvalid the cycle after, bresp OKAY.
REQ-026 SHALL cover: W 3 cycles before AW -> single o_reg_wen after AW handshake with correct data; bready held low 5 cycles -> bvalid stays high.
REQ-027 SHALL cover: AR 16'h0010 with RD_LATENCY=2, i_reg_rdata=64'hA5A5 two cycles after ren -> rdata 64'hA5A5, rresp OKAY, rvalid held until rready.
REQ-028 SHALL cover: arvalid and awvalid/wvalid asserted in the same IDLE cycle -> write completes first, read accepted only after bvalid/bready handshake.
REQ-029 SHALL cover: wstrb 8'h0F -> no o_reg_wen, bresp SLVERR; with TLK2711_AXIL_DECERR_EN, read of 16'h0200 -> no o_reg_ren, rresp DECERR, rdata 0.
REQ-030 SHALL cover: ps_rst asserted during RD_WAIT -> outputs zero immediately, no rvalid after release, next AR completes normally.
